multdiv_pipe_unit: RTL and testbench

- Iterative signed multiply/divide unit sitting beside the execute stage.
- Captures a mul/div instruction from X into its own pending slot P, runs a multi-cycle datapath, and raises a one-cycle result strobe with an exception flag.
- Its P instruction, NOP indication and exception-valid outputs feed the multdiv hazard/bypass control and the writeback mux.

---
 rtl/multdiv_pipe_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_multdiv_pipe_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_pipe_unit.sv
// multdiv_pipe_unit: iterative signed multiply/divide unit beside the X stage.
// Captures a mul/div from X into its pending slot P, iterates for a fixed
// number of edges, then strobes result_valid for one cycle with an exception
// flag.
//
// Optional build macro: MULTDIV_RADIX4_EN
//   defined   -> multiply uses radix-4 Booth (ITER_CYCLES/2 edges)
//   undefined -> multiply uses radix-2 Booth (ITER_CYCLES edges)
//   Divide is radix-2 restoring in both builds; results are identical.
//
// Ports:
//   clock, reset      rising-edge clock, async active-low reset
//   x_insn, x_valid   instruction in X and its valid bit
//   operand_a/b       bypassed rs/rt values for x_insn
//   cancel            flush; aborts any in-flight operation
//   p_insn, is_nop    instruction held in P (0 when idle), P-empty flag
//   busy, stall_req   op in flight; X must hold a mul/div while busy
//   result, exc       last completed result and its exception flag
//   result_valid      one-cycle completion strobe
//   is_exc_valid      result_valid & exc
//
// state  | meaning
// IDLE   | P empty, waiting for a mul/div in X
// RUN    | iterating, one step per edge
// DONE   | result_valid high for this one cycle
module multdiv_pipe_unit #(
  parameter logic [4:0] MUL_ALUOP   = 5'b00110,
  parameter logic [4:0] DIV_ALUOP   = 5'b00111,
  parameter int         ITER_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] x_insn,
  input  logic        x_valid,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        cancel,
  output logic [31:0] p_insn,
  output logic        is_nop,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        exc,
  output logic        is_exc_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] DIV_LAST = 6'(ITER_CYCLES - 1);
`ifdef MULTDIV_RADIX4_EN
  localparam logic [5:0] MUL_LAST = 6'(ITER_CYCLES / 2 - 1);
`else
  localparam logic [5:0] MUL_LAST = 6'(ITER_CYCLES - 1);
`endif

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] p_insn_q, p_insn_d;
  logic        is_nop_q, is_nop_d;
  logic        busy_q, busy_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        op_div_q, op_div_d;
  // multiply datapath: Booth digits consumed from the low end of mplier
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic        prev_q, prev_d;
  // divide datapath: restoring division on magnitudes
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_q, neg_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  logic        is_md;
  logic [31:0] a_abs, b_abs;
  logic [63:0] mul_add, acc_nx, mcand_nx;
  logic [31:0] mplier_nx;
  logic        prev_nx;
  logic [32:0] rem_sh;
  logic [31:0] rem_nx, quo_nx;
  logic        last_iter;

  always_comb begin
    is_md = x_valid && (x_insn[31:27] == 5'd0) &&
            ((x_insn[6:2] == MUL_ALUOP) || (x_insn[6:2] == DIV_ALUOP));
    a_abs = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
    b_abs = operand_b[31] ? (~operand_b + 32'd1) : operand_b;
  end

  // one multiply step
  always_comb begin
    mul_add = 64'd0;
`ifdef MULTDIV_RADIX4_EN
    case ({mplier_q[1:0], prev_q})
      3'b001, 3'b010: mul_add = mcand_q;
      3'b011:         mul_add = {mcand_q[62:0], 1'b0};
      3'b100:         mul_add = -{mcand_q[62:0], 1'b0};
      3'b101, 3'b110: mul_add = -mcand_q;
      default:        mul_add = 64'd0;
    endcase
    mcand_nx  = {mcand_q[61:0], 2'b00};
    mplier_nx = {2'b00, mplier_q[31:2]};
    prev_nx   = mplier_q[1];
`else
    case ({mplier_q[0], prev_q})
      2'b01:   mul_add = mcand_q;
      2'b10:   mul_add = -mcand_q;
      default: mul_add = 64'd0;
    endcase
    mcand_nx  = {mcand_q[62:0], 1'b0};
    mplier_nx = {1'b0, mplier_q[31:1]};
    prev_nx   = mplier_q[0];
`endif
    acc_nx = acc_q + mul_add;
  end

  // one divide step
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    if (rem_sh >= {1'b0, dvsr_q}) begin
      rem_nx = rem_sh[31:0] - dvsr_q;
      quo_nx = {quo_q[30:0], 1'b1};
    end else begin
      rem_nx = rem_sh[31:0];
      quo_nx = {quo_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_insn_d = p_insn_q;
    is_nop_d = is_nop_q;
    busy_d   = busy_q;
    result_d = result_q;
    exc_d    = exc_q;
    op_div_d = op_div_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prev_d   = prev_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    last_iter = op_div_q ? (dz_q || (cnt_q == DIV_LAST)) : (cnt_q == MUL_LAST);

    case (state_q)
      S_RUN: begin
        cnt_d    = cnt_q + 6'd1;
        acc_d    = acc_nx;
        mcand_d  = mcand_nx;
        mplier_d = mplier_nx;
        prev_d   = prev_nx;
        rem_d    = rem_nx;
        quo_d    = quo_nx;
        if (last_iter) begin
          state_d = S_DONE;
          if (op_div_q) begin
            result_d = dz_q ? 32'd0 : (neg_q ? -quo_nx : quo_nx);
            exc_d    = dz_q || ovf_q;
          end else begin
            result_d = acc_nx[31:0];
            exc_d    = (acc_nx[63:32] != {32{acc_nx[31]}});
          end
        end
      end
      default: begin
        // IDLE and DONE: DONE always leaves P, a waiting mul/div may re-fill it
        if (state_q == S_DONE) begin
          state_d  = S_IDLE;
          p_insn_d = 32'd0;
          is_nop_d = 1'b1;
          busy_d   = 1'b0;
        end
        if (is_md) begin
          state_d  = S_RUN;
          cnt_d    = 6'd0;
          p_insn_d = x_insn;
          is_nop_d = 1'b0;
          busy_d   = 1'b1;
          op_div_d = (x_insn[6:2] == DIV_ALUOP);
          acc_d    = 64'd0;
          mcand_d  = {{32{operand_a[31]}}, operand_a};
          mplier_d = operand_b;
          prev_d   = 1'b0;
          rem_d    = 32'd0;
          quo_d    = a_abs;
          dvsr_d   = b_abs;
          neg_d    = operand_a[31] ^ operand_b[31];
          ovf_d    = (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
          dz_d     = (operand_b == 32'd0);
        end
      end
    endcase

    // flush beats everything, including a same-edge capture
    if (cancel) begin
      state_d  = S_IDLE;
      p_insn_d = 32'd0;
      is_nop_d = 1'b1;
      busy_d   = 1'b0;
      result_d = result_q;
      exc_d    = exc_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      p_insn_q <= 32'd0;
      is_nop_q <= 1'b1;
      busy_q   <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      op_div_q <= 1'b0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prev_q   <= 1'b0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_insn_q <= p_insn_d;
      is_nop_q <= is_nop_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      op_div_q <= op_div_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prev_q   <= prev_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
    end
  end

  assign p_insn       = p_insn_q;
  assign is_nop       = is_nop_q;
  assign busy         = busy_q;
  assign stall_req    = is_md & busy_q & ~cancel;
  assign result       = result_q;
  assign result_valid = (state_q == S_DONE);
  assign exc          = exc_q;
  assign is_exc_valid = result_valid & exc_q;

endmodule

// File: tb/tb_multdiv_pipe_unit.sv
// Directed bench for multdiv_pipe_unit with hand-computed expected values.
module tb_multdiv_pipe_unit;

`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_LAT = 16;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  // opcode 0, rd 1, rs 2, rt 3, ALU op 6/7
  localparam logic [31:0] MUL_I  = 32'h0044_3018;
  localparam logic [31:0] DIV_I  = 32'h0044_301C;
  // same multiply with rd 5
  localparam logic [31:0] MUL_I2 = 32'h0144_3018;

  logic        clock;
  logic        reset;
  logic [31:0] x_insn;
  logic        x_valid;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        cancel;
  logic [31:0] p_insn;
  logic        is_nop;
  logic        busy;
  logic        stall_req;
  logic [31:0] result;
  logic        result_valid;
  logic        exc;
  logic        is_exc_valid;

  int n_chk;
  int n_err;

  multdiv_pipe_unit dut (
    .clock        (clock),
    .reset        (reset),
    .x_insn       (x_insn),
    .x_valid      (x_valid),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .cancel       (cancel),
    .p_insn       (p_insn),
    .is_nop       (is_nop),
    .busy         (busy),
    .stall_req    (stall_req),
    .result       (result),
    .result_valid (result_valid),
    .exc          (exc),
    .is_exc_valid (is_exc_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op from X; returns at the negedge where result_valid is seen,
  // lat = edges after E0 at which the strobe became visible (-1 on timeout).
  task automatic run_op(input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    @(negedge clock);
    x_insn = insn; x_valid = 1'b1; operand_a = a; operand_b = b;
    @(posedge clock);
    @(negedge clock);
    x_valid = 1'b0; x_insn = 32'd0;
    check("p_insn_after_e0", p_insn, insn);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (result_valid) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
  endtask

  int  lat;
  int  cnt;
  logic stall_ok;
  logic seen;

  initial begin
    n_chk = 0; n_err = 0;
    reset = 1'b0; x_insn = 32'd0; x_valid = 1'b0;
    operand_a = 32'd0; operand_b = 32'd0; cancel = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_p_insn", p_insn, 32'd0);
    check("rst_is_nop", 32'(is_nop), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rvalid", 32'(result_valid), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // 7 * -6 = -42
    run_op(MUL_I, 32'd7, 32'hFFFF_FFFA, lat);
    check("mul1_lat", 32'(lat), 32'(MUL_LAT));
    check("mul1_result", result, 32'hFFFF_FFD6);
    check("mul1_exc", 32'(exc), 32'd0);
    check("mul1_excv", 32'(is_exc_valid), 32'd0);
    check("mul1_busy_done", 32'(busy), 32'd1);
    @(negedge clock);
    check("mul1_strobe_off", 32'(result_valid), 32'd0);
    check("mul1_is_nop", 32'(is_nop), 32'd1);
    check("mul1_p_clr", p_insn, 32'd0);
    check("mul1_busy_off", 32'(busy), 32'd0);

    // 2^16 * 2^16 overflows 32 bits
    run_op(MUL_I, 32'h0001_0000, 32'h0001_0000, lat);
    check("mul2_lat", 32'(lat), 32'(MUL_LAT));
    check("mul2_result", result, 32'd0);
    check("mul2_exc", 32'(exc), 32'd1);
    check("mul2_excv", 32'(is_exc_valid), 32'd1);
    @(negedge clock);
    check("mul2_excv_off", 32'(is_exc_valid), 32'd0);

    // 0x7FFFFFFF * 2 = 0xFFFFFFFE positive -> overflow
    run_op(MUL_I, 32'h7FFF_FFFF, 32'd2, lat);
    check("mul3_result", result, 32'hFFFF_FFFE);
    check("mul3_exc", 32'(exc), 32'd1);

    // 0x80000000 * 1 fits exactly
    run_op(MUL_I, 32'h8000_0000, 32'd1, lat);
    check("mul4_result", result, 32'h8000_0000);
    check("mul4_exc", 32'(exc), 32'd0);

    // -7 / 2 = -3 (truncate toward zero)
    run_op(DIV_I, 32'hFFFF_FFF9, 32'd2, lat);
    check("div1_lat", 32'(lat), 32'(DIV_LAT));
    check("div1_result", result, 32'hFFFF_FFFD);
    check("div1_exc", 32'(exc), 32'd0);

    // 5 / 0
    run_op(DIV_I, 32'd5, 32'd0, lat);
    check("divz_lat", 32'(lat), 32'd1);
    check("divz_result", result, 32'd0);
    check("divz_exc", 32'(exc), 32'd1);
    check("divz_excv", 32'(is_exc_valid), 32'd1);

    // 0x80000000 / -1 overflow
    run_op(DIV_I, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("divo_lat", 32'(lat), 32'(DIV_LAT));
    check("divo_result", result, 32'h8000_0000);
    check("divo_exc", 32'(exc), 32'd1);

    // 100 / -7 = -14
    run_op(DIV_I, 32'd100, 32'hFFFF_FFF9, lat);
    check("div2_result", result, 32'hFFFF_FFF2);
    check("div2_exc", 32'(exc), 32'd0);

    // back-to-back: 3*5 then -4*9 held in X while busy
    @(negedge clock);
    x_insn = MUL_I; x_valid = 1'b1; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clock);
    @(negedge clock);
    x_insn = MUL_I2; operand_a = 32'hFFFF_FFFC; operand_b = 32'd9;
    stall_ok = 1'b1;
    cnt = 0;
    while (!result_valid && cnt < 100) begin
      if (!stall_req) stall_ok = 1'b0;
      @(negedge clock);
      cnt++;
    end
    check("b2b_stall_run", 32'(stall_ok), 32'd1);
    check("b2b_first_result", result, 32'd15);
    cnt = 0;
    @(posedge clock);
    cnt = 1;
    @(negedge clock);
    x_valid = 1'b0; x_insn = 32'd0;
    check("b2b_p_insn2", p_insn, MUL_I2);
    check("b2b_busy", 32'(busy), 32'd1);
    while (!result_valid && cnt < 100) begin
      @(posedge clock);
      cnt++;
      @(negedge clock);
    end
    check("b2b_gap", 32'(cnt), 32'(MUL_LAT + 1));
    check("b2b_second_result", result, 32'hFFFF_FFDC);

    // cancel a divide at E10
    @(negedge clock);
    x_insn = DIV_I; x_valid = 1'b1; operand_a = 32'd100; operand_b = 32'd3;
    @(posedge clock);
    @(negedge clock);
    x_valid = 1'b0; x_insn = 32'd0;
    repeat (9) @(negedge clock);
    cancel = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_p_insn", p_insn, 32'd0);
    check("cancel_is_nop", 32'(is_nop), 32'd1);
    check("cancel_result_kept", result, 32'hFFFF_FFDC);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (result_valid) seen = 1'b1;
    end
    check("cancel_no_strobe", 32'(seen), 32'd0);

    // cancel and issue on the same edge
    x_insn = MUL_I; x_valid = 1'b1; operand_a = 32'd2; operand_b = 32'd2; cancel = 1'b1;
    check("cancel_issue_stall", 32'(stall_req), 32'd0);
    @(posedge clock);
    @(negedge clock);
    x_valid = 1'b0; x_insn = 32'd0; cancel = 1'b0;
    check("cancel_issue_busy", 32'(busy), 32'd0);
    check("cancel_issue_p", p_insn, 32'd0);

    // reset mid-run
    @(negedge clock);
    x_insn = MUL_I; x_valid = 1'b1; operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clock);
    @(negedge clock);
    x_valid = 1'b0; x_insn = 32'd0;
    repeat (4) @(negedge clock);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_p_insn", p_insn, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rvalid", 32'(result_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (busy || result_valid || !is_nop) seen = 1'b1;
    end
    check("post_rst_idle", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
